// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the main memory port and mem_arbiter.
// The arbiter connects through the slave modport; the surrounding system drives the master side.
interface mem_arbiter_if;
   logic        icache_MemRead;
   logic [15:0] icache_addr;
   logic        dcache_MemRead;
   logic        dcache_MemWrite;
   logic [15:0] dcache_addr;
   logic [15:0] dcache_wdata;
   logic [15:0] mem_data_out;
   logic        mem_data_valid;

   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_in;
   logic        icache_grant;
   logic        dcache_grant;
   logic        icache_MemDataValid;
   logic        dcache_MemDataValid;
   logic [15:0] rdata;
   logic        dcache_write_done;

   modport slave (
      input  icache_MemRead, icache_addr,
      input  dcache_MemRead, dcache_MemWrite, dcache_addr, dcache_wdata,
      input  mem_data_out, mem_data_valid,
      output mem_enable, mem_wr, mem_addr, mem_data_in,
      output icache_grant, dcache_grant,
      output icache_MemDataValid, dcache_MemDataValid,
      output rdata, dcache_write_done
   );

   modport master (
      output icache_MemRead, icache_addr,
      output dcache_MemRead, dcache_MemWrite, dcache_addr, dcache_wdata,
      output mem_data_out, mem_data_valid,
      input  mem_enable, mem_wr, mem_addr, mem_data_in,
      input  icache_grant, dcache_grant,
      input  icache_MemDataValid, dcache_MemDataValid,
      input  rdata, dcache_write_done
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache/D-cache fills and D-cache write-through onto one pipelined memory port.
// Build macro ARB_ROUND_ROBIN_EN: alternate the fill grant when both caches request reads together.
module mem_arbiter_chk #(
   parameter int LATENCY = 4,
   parameter int CNT_W   = 3
) (
   input logic             clk,
   input logic             rst,
   input logic             i_issue,
   input logic             i_beat,
   input logic [CNT_W-1:0] i_outstanding
);
   // An issue without a returning beat must never push the in-flight count past LATENCY.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      (i_issue && !i_beat) |-> (int'(i_outstanding) < LATENCY));
endmodule

module mem_arbiter #(
   parameter int LATENCY = 4,
   parameter int CNT_W   = 3
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DWRITE = 2'd1,
      DFILL  = 2'd2,
      IFILL  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] w_outstanding_nxt;
   logic             w_fill;
   logic             w_owner_rd;
   logic             w_issue;
   logic             w_beat;
   logic             w_drained;

   assign w_fill     = (r_state == DFILL) || (r_state == IFILL);
   assign w_owner_rd = (r_state == DFILL) ? bus.dcache_MemRead :
                       (r_state == IFILL) ? bus.icache_MemRead : 1'b0;
   assign w_issue    = w_fill && w_owner_rd;
   // Beats outside a fill are stray and never reach the counter or a cache.
   assign w_beat     = w_fill && bus.mem_data_valid;
   assign w_drained  = !w_owner_rd && (r_outstanding == CNT_ZERO) && !bus.mem_data_valid;
   assign bus.rdata  = bus.mem_data_out;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_owner;  // 1'b1: last fill went to the D-cache

   // Remember which cache received the most recent fill grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_owner <= 1'b0;
      end else if ((r_state == IDLE) && (w_next_state == DFILL)) begin
         r_last_owner <= 1'b1;
      end else if ((r_state == IDLE) && (w_next_state == IFILL)) begin
         r_last_owner <= 1'b0;
      end else begin
         r_last_owner <= r_last_owner;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: writes win in IDLE, fills hold until the owner releases and drains.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (bus.dcache_MemWrite) begin
               w_next_state = DWRITE;
            end else if (bus.dcache_MemRead && bus.icache_MemRead) begin
`ifdef ARB_ROUND_ROBIN_EN
               w_next_state = r_last_owner ? IFILL : DFILL;
`else
               w_next_state = DFILL;
`endif
            end else if (bus.dcache_MemRead) begin
               w_next_state = DFILL;
            end else if (bus.icache_MemRead) begin
               w_next_state = IFILL;
            end else begin
               w_next_state = IDLE;
            end
         end
         DWRITE: begin
            w_next_state = IDLE;
         end
         DFILL, IFILL: begin
            if (w_drained) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = r_state;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Outstanding-read count; a beat with nothing in flight leaves it at zero.
   always_comb begin
      w_outstanding_nxt = r_outstanding;
      if (w_issue && !w_beat) begin
         w_outstanding_nxt = r_outstanding + CNT_ONE;
      end else if (w_beat && !w_issue && (r_outstanding != CNT_ZERO)) begin
         w_outstanding_nxt = r_outstanding - CNT_ONE;
      end else begin
         w_outstanding_nxt = r_outstanding;
      end
   end

   // Outstanding counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_outstanding <= CNT_ZERO;
      end else begin
         r_outstanding <= w_outstanding_nxt;
      end
   end

   // Memory port, grants and routed valids, decoded from state and live requests.
   always_comb begin
      bus.mem_enable          = 1'b0;
      bus.mem_wr              = 1'b0;
      bus.mem_addr            = 16'h0000;
      bus.mem_data_in         = 16'h0000;
      bus.icache_grant        = 1'b0;
      bus.dcache_grant        = 1'b0;
      bus.icache_MemDataValid = 1'b0;
      bus.dcache_MemDataValid = 1'b0;
      bus.dcache_write_done   = 1'b0;
      case (r_state)
         DWRITE: begin
            bus.mem_enable        = 1'b1;
            bus.mem_wr            = 1'b1;
            bus.mem_addr          = bus.dcache_addr;
            bus.mem_data_in       = bus.dcache_wdata;
            bus.dcache_write_done = 1'b1;
         end
         DFILL: begin
            bus.dcache_grant        = 1'b1;
            bus.mem_enable          = bus.dcache_MemRead;
            bus.mem_addr            = bus.dcache_addr;
            bus.dcache_MemDataValid = bus.mem_data_valid;
         end
         IFILL: begin
            bus.icache_grant        = 1'b1;
            bus.mem_enable          = bus.icache_MemRead;
            bus.mem_addr            = bus.icache_addr;
            bus.icache_MemDataValid = bus.mem_data_valid;
         end
         default: begin
            bus.mem_enable = 1'b0;
         end
      endcase
   end

   mem_arbiter_chk #(
      .LATENCY (LATENCY),
      .CNT_W   (CNT_W)
   ) u_chk (
      .clk           (clk),
      .rst           (rst),
      .i_issue       (w_issue),
      .i_beat        (w_beat),
      .i_outstanding (r_outstanding)
   );
endmodule
